// File: rtl/display_keypad_scanner.sv
// Digit-multiplexed display latch with keypad return scanning.
// Captures the pattern of each scanned digit once its index has settled; blanks stale slots; debounces keys.
module display_keypad_scanner #(
    parameter int NUM_DIGITS    = 8,
    parameter int SEG_W         = 9,
    parameter int ROWS          = 3,
    parameter int IDX_W         = 3,
    parameter int SETTLE        = 1,
    parameter int DEB_CNT       = 4,
    parameter int BLANK_TIMEOUT = 4096,
    parameter int INVERT_IDX    = 1
) (
    input  logic                        clk25,
    input  logic                        reset,
    input  logic                        clken,
    input  logic [IDX_W-1:0]            scan_idx,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [NUM_DIGITS*ROWS-1:0]  keys,
    output logic [NUM_DIGITS*SEG_W-1:0] seg_out,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic [ROWS-1:0]             row_n,
    output logic                        key_any
);

    localparam int NKEYS = NUM_DIGITS * ROWS;
    localparam int DW_W  = 5;
    localparam int RC_W  = (BLANK_TIMEOUT > 0) ? $clog2(BLANK_TIMEOUT + 1) : 1;
    localparam bit BLANK_EN = (BLANK_TIMEOUT != 0);
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(SETTLE + 1);
    localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(BLANK_TIMEOUT);
    localparam logic [7:0]       DEB_MAX   = 8'(DEB_CNT);

    logic [IDX_W-1:0] prev_idx_q;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [IDX_W-1:0] slot;
    logic             in_range;
    logic             same_idx;
    logic             latch_fire;
    logic [NKEYS-1:0] deb_vec;
    logic [ROWS-1:0]  row_n_q, row_n_d;
    logic             key_any_q;

    // Inverting the index is just a bitwise complement: (2**IDX_W-1) - x == ~x.
    assign slot     = (INVERT_IDX != 0) ? ~scan_idx : scan_idx;
    assign in_range = {1'b0, slot} < (IDX_W+1)'(NUM_DIGITS);
    assign same_idx = (scan_idx == prev_idx_q);

    always_comb begin
        dwell_d = dwell_q;
        if (same_idx) begin
            dwell_d = (dwell_q >= DWELL_MAX) ? DWELL_MAX : dwell_q + 1'b1;
        end else begin
            dwell_d = DW_W'(1);
        end
    end

    // A dwell latches only on the tick its count first reaches the target.
    assign latch_fire = clken && in_range && (dwell_d == DWELL_MAX)
                        && !(same_idx && (dwell_q == DWELL_MAX));

    always_ff @(posedge clk25) begin
        if (reset) begin
            prev_idx_q <= '1;
            dwell_q    <= '0;
        end else if (clken) begin
            prev_idx_q <= scan_idx;
            dwell_q    <= dwell_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [SEG_W-1:0] seg_q;
            logic             valid_q;
            logic [RC_W-1:0]  rcnt_q;
            logic [RC_W-1:0]  rcnt_inc;
            logic             hit;

            assign hit      = latch_fire && (slot == IDX_W'(gi));
            assign rcnt_inc = rcnt_q + 1'b1;

            always_ff @(posedge clk25) begin
                if (reset) begin
                    seg_q   <= '0;
                    valid_q <= 1'b0;
                    rcnt_q  <= '0;
                end else if (clken) begin
                    if (hit) begin
                        seg_q   <= seg_in;
                        valid_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else if (BLANK_EN && (rcnt_q != RC_MAX)) begin
                        rcnt_q <= rcnt_inc;
                        if (rcnt_inc == RC_MAX) begin
                            seg_q   <= '0;
                            valid_q <= 1'b0;
                        end
                    end
                end
            end

            assign seg_out[gi*SEG_W +: SEG_W] = seg_q;
            assign digit_valid[gi]            = valid_q;
        end

        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic       deb_q;
            logic [7:0] dcnt_q;
            logic [7:0] dcnt_inc;

            assign dcnt_inc = dcnt_q + 8'd1;

            always_ff @(posedge clk25) begin
                if (reset) begin
                    deb_q  <= 1'b0;
                    dcnt_q <= '0;
                end else if (clken) begin
                    if (keys[gi] != deb_q) begin
                        if (dcnt_inc == DEB_MAX) begin
                            deb_q  <= ~deb_q;
                            dcnt_q <= '0;
                        end else begin
                            dcnt_q <= dcnt_inc;
                        end
                    end else begin
                        dcnt_q <= '0;
                    end
                end
            end

            assign deb_vec[gi] = deb_q;
        end
    endgenerate

    always_comb begin
        row_n_d = '1;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (in_range && (slot == IDX_W'(s))) begin
                row_n_d = ~deb_vec[s*ROWS +: ROWS];
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            row_n_q   <= '1;
            key_any_q <= 1'b0;
        end else if (clken) begin
            row_n_q   <= row_n_d;
            key_any_q <= |deb_vec;
        end
    end

    assign row_n   = row_n_q;
    assign key_any = key_any_q;

endmodule

// File: tb/tb_display_keypad_scanner.sv
// Directed bench: default instance, a short-timeout instance and a 6-digit non-inverted instance
// share the scan stimulus; expected values are hand-derived.
module tb_display_keypad_scanner;

    logic        clk25 = 1'b0;
    logic        reset;
    logic        clken;
    logic [2:0]  scan_idx;
    logic [8:0]  seg_in;
    logic [23:0] keys;
    logic [17:0] keys6;

    logic [71:0] dut_seg, bt_seg;
    logic [7:0]  dut_valid, bt_valid;
    logic [2:0]  dut_row_n, bt_row_n, nd_row_n;
    logic        dut_any, bt_any, nd_any;
    logic [53:0] nd_seg;
    logic [5:0]  nd_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk25 = ~clk25;

    display_keypad_scanner u_dut (
        .clk25(clk25), .reset(reset), .clken(clken), .scan_idx(scan_idx), .seg_in(seg_in),
        .keys(keys), .seg_out(dut_seg), .digit_valid(dut_valid), .row_n(dut_row_n), .key_any(dut_any)
    );

    display_keypad_scanner #(.BLANK_TIMEOUT(8)) u_bt (
        .clk25(clk25), .reset(reset), .clken(clken), .scan_idx(scan_idx), .seg_in(seg_in),
        .keys(keys), .seg_out(bt_seg), .digit_valid(bt_valid), .row_n(bt_row_n), .key_any(bt_any)
    );

    display_keypad_scanner #(.NUM_DIGITS(6), .IDX_W(3), .INVERT_IDX(0)) u_nd6 (
        .clk25(clk25), .reset(reset), .clken(clken), .scan_idx(scan_idx), .seg_in(seg_in),
        .keys(keys6), .seg_out(nd_seg), .digit_valid(nd_valid), .row_n(nd_row_n), .key_any(nd_any)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input logic [2:0] idx, input logic [8:0] seg, input logic en, input int n);
        repeat (n) begin
            scan_idx = idx;
            seg_in   = seg;
            clken    = en;
            @(posedge clk25);
            #1;
        end
    endtask

    logic [71:0] exp_seg;

    initial begin
        reset = 1'b1; clken = 1'b0; scan_idx = '0; seg_in = '0; keys = '0; keys6 = '0;
        repeat (2) @(posedge clk25);
        #1;
        check("rst_seg", dut_seg, 72'h0);
        check("rst_valid", {64'h0, dut_valid}, 72'h0);
        check("rst_row_n", {69'h0, dut_row_n}, 72'h7);
        check("rst_key_any", {71'h0, dut_any}, 72'h0);
        reset = 1'b0;

        // Index toggling every tick never settles.
        for (int i = 0; i < 6; i++) step((i % 2 == 1) ? 3'd6 : 3'd7, 9'h0AA, 1'b1, 1);
        check("toggle_no_latch", dut_seg, 72'h0);
        check("toggle_valid", {64'h0, dut_valid}, 72'h0);

        // Two-tick dwell on index 7 latches slot 0.
        step(3'd7, 9'h03F, 1'b1, 1);
        check("dwell_tick1", dut_seg, 72'h0);
        step(3'd7, 9'h03F, 1'b1, 1);
        check("dwell_latch_seg", dut_seg, 72'h03F);
        check("dwell_latch_valid", {64'h0, dut_valid}, 72'h01);
        check("nd6_oor_seg", {18'h0, nd_seg}, 72'h0);
        check("nd6_oor_row_n", {69'h0, nd_row_n}, 72'h7);
        step(3'd7, 9'h155, 1'b1, 1);
        check("one_latch_per_dwell", dut_seg, 72'h03F);

        // Blanking with an 8-tick timeout: latch slot 3, then scan only slot 0.
        step(3'd4, 9'h1FF, 1'b1, 2);
        check("bt_latch3", {63'h0, bt_seg[27 +: 9]}, 72'h1FF);
        step(3'd7, 9'h03F, 1'b1, 7);
        check("bt_tick7_seg", {63'h0, bt_seg[27 +: 9]}, 72'h1FF);
        check("bt_tick7_valid", {71'h0, bt_valid[3]}, 72'h1);
        step(3'd7, 9'h03F, 1'b1, 1);
        check("bt_blank_seg", {63'h0, bt_seg[27 +: 9]}, 72'h0);
        check("bt_blank_valid", {71'h0, bt_valid[3]}, 72'h0);
        check("dut_no_blank", {63'h0, dut_seg[27 +: 9]}, 72'h1FF);

        // Re-latch landing exactly on the timeout tick.
        step(3'd4, 9'h0F0, 1'b1, 2);
        step(3'd7, 9'h03F, 1'b1, 6);
        step(3'd4, 9'h00F, 1'b1, 2);
        check("bt_latch_wins_valid", {71'h0, bt_valid[3]}, 72'h1);
        check("bt_latch_wins_seg", {63'h0, bt_seg[27 +: 9]}, 72'h00F);
        step(3'd4, 9'h00F, 1'b1, 1);
        check("bt_after_wins_valid", {71'h0, bt_valid[3]}, 72'h1);

        // Debounce of key (slot1,row2) = bit 5.
        keys[5] = 1'b1;
        step(3'd6, 9'h000, 1'b1, 3);
        keys[5] = 1'b0;
        step(3'd6, 9'h000, 1'b1, 4);
        check("bounce_key_any", {71'h0, dut_any}, 72'h0);
        check("bounce_row_n", {69'h0, dut_row_n}, 72'h7);
        keys[5] = 1'b1;
        step(3'd6, 9'h000, 1'b0, 10);
        check("clken_hold_key_any", {71'h0, dut_any}, 72'h0);
        step(3'd6, 9'h000, 1'b1, 6);
        check("held_key_any", {71'h0, dut_any}, 72'h1);
        check("held_row_n", {69'h0, dut_row_n}, 72'h3);
        step(3'd7, 9'h000, 1'b1, 1);
        check("other_slot_row_n", {69'h0, dut_row_n}, 72'h7);
        keys[3] = 1'b1;
        step(3'd6, 9'h000, 1'b1, 6);
        check("multi_row_n", {69'h0, dut_row_n}, 72'h2);
        keys = '0;
        step(3'd6, 9'h000, 1'b1, 6);
        check("release_key_any", {71'h0, dut_any}, 72'h0);
        check("release_row_n", {69'h0, dut_row_n}, 72'h7);

        // Reset during a dwell with data and a pressed key present.
        keys[0] = 1'b1;
        step(3'd6, 9'h000, 1'b1, 6);
        check("pre_rst_key_any", {71'h0, dut_any}, 72'h1);
        step(3'd5, 9'h123, 1'b1, 1);
        reset = 1'b1;
        clken = 1'b0;
        @(posedge clk25);
        #1;
        check("mid_rst_seg", dut_seg, 72'h0);
        check("mid_rst_valid", {64'h0, dut_valid}, 72'h0);
        check("mid_rst_row_n", {69'h0, dut_row_n}, 72'h7);
        check("mid_rst_key_any", {71'h0, dut_any}, 72'h0);
        reset = 1'b0;
        keys = '0;
        step(3'd5, 9'h123, 1'b1, 1);
        check("post_rst_tick1", dut_seg, 72'h0);
        step(3'd5, 9'h123, 1'b1, 1);
        exp_seg = '0;
        exp_seg[18 +: 9] = 9'h123;
        check("post_rst_latch_seg", dut_seg, exp_seg);
        check("post_rst_latch_valid", {64'h0, dut_valid}, 72'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
